// File: rtl/id_fwd_stage.sv
// Instruction-decode stage: IF->ID slot register, SRAM word buffer for holds,
// operand forwarding (EX > MEM > WB > regfile), load-use hazard detection,
// branch/jump resolution and a saturating load-use stall counter.
//
// Slot handshake: the slot holds a valid instruction when valid_r=1. It is
// handed to EX (issue_valid=1) in a cycle where it is valid, no load-use
// hazard is detected (stallreq=0) and the controller is not holding ID
// (hold=0). Whenever the slot is valid but not issued, it stays in place
// until hold drops. stallreq is a request only; the controller must answer
// it by raising hold for IF and ID and inserting a bubble into EX.
module id_fwd_stage #(
  parameter int DW    = 32,
  parameter int RAW   = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             flush,
  input  logic             if_valid,
  input  logic [DW-1:0]    if_pc,
  input  logic [31:0]      inst_sram_rdata,
  output logic [RAW-1:0]   rf_raddr1,
  output logic [RAW-1:0]   rf_raddr2,
  input  logic [DW-1:0]    rf_rdata1,
  input  logic [DW-1:0]    rf_rdata2,
  input  logic             ex_we,
  input  logic             ex_is_load,
  input  logic [RAW-1:0]   ex_waddr,
  input  logic [DW-1:0]    ex_wdata,
  input  logic             mem_we,
  input  logic [RAW-1:0]   mem_waddr,
  input  logic [DW-1:0]    mem_wdata,
  input  logic             wb_we,
  input  logic [RAW-1:0]   wb_waddr,
  input  logic [DW-1:0]    wb_wdata,
  output logic             issue_valid,
  output logic [DW-1:0]    id_pc,
  output logic [31:0]      id_inst,
  output logic [DW-1:0]    rs_val,
  output logic [DW-1:0]    rt_val,
  output logic             stallreq,
  output logic             br_taken,
  output logic [DW-1:0]    br_target,
  output logic [CNT_W-1:0] lu_stall_cnt
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_LUI     = 6'h0f;

  logic          valid_r;
  logic [DW-1:0] pc_r;
  logic          buf_v;
  logic [31:0]   buf_inst;

  logic [5:0]     op;
  logic [5:0]     func;
  logic [4:0]     rt_field;
  logic [RAW-1:0] rs_a;
  logic [RAW-1:0] rt_a;
  logic           uses_rs;
  logic           uses_rt;
  logic [DW-1:0]  pc4;
  logic [DW-1:0]  off;
  logic           is_br;
  logic           cond;
  logic [DW-1:0]  tgt;

  // Slot register: flush kills, hold keeps, otherwise load from IF.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      pc_r    <= '0;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (!hold) begin
      valid_r <= if_valid;
      pc_r    <= if_pc;
    end
  end

  // The SRAM only returns the word for the PC latched last cycle, so on the
  // first hold edge we grab it; later hold cycles read the buffered copy.
  always_ff @(posedge clk) begin
    if (rst || flush || !hold) begin
      buf_v <= 1'b0;
    end else if (!buf_v && valid_r) begin
      buf_v    <= 1'b1;
      buf_inst <= inst_sram_rdata;
    end
  end

  // Instruction select; an empty slot decodes as a NOP.
  always_comb begin
    id_inst = 32'h0;
    if (valid_r) id_inst = buf_v ? buf_inst : inst_sram_rdata;
  end

  assign id_pc     = pc_r;
  assign op        = id_inst[31:26];
  assign func      = id_inst[5:0];
  assign rt_field  = id_inst[20:16];
  assign rs_a      = RAW'(id_inst[25:21]);
  assign rt_a      = RAW'(id_inst[20:16]);
  assign rf_raddr1 = rs_a;
  assign rf_raddr2 = rt_a;

  // rs operand: $0 is hard zero, then nearest producer wins.
  always_comb begin
    rs_val = rf_rdata1;
    if (rs_a == '0)                        rs_val = '0;
    else if (ex_we && ex_waddr == rs_a)    rs_val = ex_wdata;
    else if (mem_we && mem_waddr == rs_a)  rs_val = mem_wdata;
    else if (wb_we && wb_waddr == rs_a)    rs_val = wb_wdata;
  end

  // rt operand: same priority as rs.
  always_comb begin
    rt_val = rf_rdata2;
    if (rt_a == '0)                        rt_val = '0;
    else if (ex_we && ex_waddr == rt_a)    rt_val = ex_wdata;
    else if (mem_we && mem_waddr == rt_a)  rt_val = mem_wdata;
    else if (wb_we && wb_waddr == rt_a)    rt_val = wb_wdata;
  end

  // Which operands the instruction actually reads; shifts by immediate use
  // only rt, lui/j/jal use neither register field as a source.
  always_comb begin
    uses_rs = !((op == OP_LUI) || (op == OP_J) || (op == OP_JAL) ||
                ((op == OP_SPECIAL) &&
                 ((func == 6'h00) || (func == 6'h02) || (func == 6'h03))));
    uses_rt = (op == OP_SPECIAL) || (op == OP_BEQ) || (op == OP_BNE) ||
              (op[5:3] == 3'b101);
  end

  assign stallreq = valid_r && ex_we && ex_is_load && (ex_waddr != '0) &&
                    ((uses_rs && ex_waddr == rs_a) ||
                     (uses_rt && ex_waddr == rt_a));

  assign issue_valid = valid_r && !stallreq && !hold;

  assign pc4 = pc_r + DW'(4);
  assign off = {{(DW-18){id_inst[15]}}, id_inst[15:0], 2'b00};

  // Branch/jump condition and target on forwarded operands.
  always_comb begin
    is_br = 1'b0;
    cond  = 1'b0;
    tgt   = '0;
    case (op)
      OP_BEQ:  begin is_br = 1'b1; cond = (rs_val == rt_val);        tgt = pc4 + off; end
      OP_BNE:  begin is_br = 1'b1; cond = (rs_val != rt_val);        tgt = pc4 + off; end
      OP_BLEZ: begin is_br = 1'b1; cond = ($signed(rs_val) <= 0);    tgt = pc4 + off; end
      OP_BGTZ: begin is_br = 1'b1; cond = ($signed(rs_val) > 0);     tgt = pc4 + off; end
      OP_REGIMM: begin
        if (rt_field == 5'd0) begin
          is_br = 1'b1; cond = ($signed(rs_val) < 0);  tgt = pc4 + off;
        end else if (rt_field == 5'd1) begin
          is_br = 1'b1; cond = ($signed(rs_val) >= 0); tgt = pc4 + off;
        end
      end
      OP_J, OP_JAL: begin
        is_br = 1'b1; cond = 1'b1;
        tgt   = {pc4[DW-1:28], id_inst[25:0], 2'b00};
      end
      OP_SPECIAL: begin
        if (func == 6'h08 || func == 6'h09) begin
          is_br = 1'b1; cond = 1'b1; tgt = rs_val;
        end
      end
      default: ;
    endcase
  end

  assign br_taken  = issue_valid && is_br && cond;
  assign br_target = br_taken ? tgt : '0;

  // Saturating count of load-use stall cycles.
  always_ff @(posedge clk) begin
    if (rst) lu_stall_cnt <= '0;
    else if (stallreq && (lu_stall_cnt != '1)) lu_stall_cnt <= lu_stall_cnt + 1'b1;
  end

endmodule

// File: doc/id_fwd_stage.md
# id_fwd_stage

Parametrised instruction-decode stage for the five-stage MIPS pipeline, placed between IF and EX. It does four jobs:
- registers the IF→ID pipeline slot with hold, bubble and flush control;
- buffers the synchronous instruction-SRAM word across multi-cycle holds so the instruction is not lost;
- resolves operand forwarding (EX > MEM > WB > regfile) and detects load-use hazards;
- resolves all branches and jumps in ID and counts load-use stall cycles.

The regfile sits outside this block; only its read ports connect here.

## Interface
Parameters:
- DW, 32, datapath and PC width
- RAW, 5, register address width (2^RAW architectural registers; register 0 is hard zero)
- CNT_W, 16, width of the saturating load-use stall counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- hold  in  1  ID must keep its slot; this is the controller stall for ID
- flush  in  1  kill the slot contents
- if_valid  in  1  IF presents a valid PC this cycle
- if_pc  in  DW  PC fetched by IF
- inst_sram_rdata  in  32  SRAM data for the PC latched last cycle
- rf_raddr1, rf_raddr2  out  RAW  rs and rt read addresses
- rf_rdata1, rf_rdata2  in  DW  regfile read data
- ex_we, ex_is_load  in  1 each  EX write enable; EX instruction is a load
- ex_waddr  in  RAW  EX destination; ex_wdata  in  DW  EX result
- mem_we  in  1; mem_waddr  in  RAW; mem_wdata  in  DW  MEM stage result
- wb_we  in  1; wb_waddr  in  RAW; wb_wdata  in  DW  WB stage result
- issue_valid  out  1  slot goes to EX this cycle
- id_pc  out  DW; id_inst  out  32  current slot PC and instruction
- rs_val, rt_val  out  DW  forwarded operands
- stallreq  out  1  load-use hazard; the controller must raise hold for IF and ID and insert a bubble into EX
- br_taken  out  1; br_target  out  DW  redirect for IF
- lu_stall_cnt  out  CNT_W  load-use stall cycles, saturating

## Operation
- **Slot register (valid_r, pc_r).**
  - rst: both cleared.
  - Else if flush: valid_r=0.
  - Else if hold: keep.
  - Else: load {if_valid, if_pc}.
  - flush has priority over hold.
- **Instruction buffer (buf_v, buf_inst).**
  - Capture: hold=1, buf_v=0 and valid_r=1 → buf_inst<=inst_sram_rdata, buf_v<=1.
  - Clear: rst, flush, or hold=0 clear buf_v.
  - Selection: id_inst = buf_v ? buf_inst : inst_sram_rdata. If valid_r=0, id_inst is forced to 0 (a NOP).
- **Register reads.** rf_raddr1=inst[25:21], rf_raddr2=inst[20:16], driven from id_inst.
- **Forwarding.** Applied per operand. Address 0 always yields 0. Otherwise take the first matching source:
  - EX (ex_we & ex_waddr==addr)
  - MEM
  - WB
  - regfile data
- **Operand use.**
  - rs is used by every instruction except lui, j, jal and sll/srl/sra (SPECIAL with func 000000/000010/000011).
  - rt is used by SPECIAL, beq, bne and stores (opcode 101xxx).
- **Load-use hazard.** stallreq = valid_r & ex_we & ex_is_load & ex_waddr≠0 & ((uses_rs & ex_waddr==rs) | (uses_rt & ex_waddr==rt)).
- **Issue.** issue_valid = valid_r & ~stallreq & ~hold.
- **Branches.** Resolved on forwarded operands; pc4 = id_pc+4, off = sign-extended imm<<2.
  - beq / bne: taken on (rs==rt) / (rs≠rt); target pc4+off.
  - blez, bgtz, bltz, bgez: signed compare of rs against 0; target pc4+off.
  - j, jal: target {pc4[DW-1:28], index, 2'b00}.
  - jr, jalr: target rs_val.
  - br_taken is asserted only when issue_valid=1 and the condition holds; otherwise br_taken=0 and br_target=0.
- **Counter.** lu_stall_cnt increments on each cycle with stallreq=1 and hold still low from the controller's view (stallreq alone is the trigger). It saturates at all-ones and clears only on rst.

## Timing
- Reset values: every output is 0 except rf_raddr1/2, which decode from 0 and are therefore also 0.
- Latency: a PC presented on IF appears at id_pc one cycle later.
- All decode, forward, hazard and branch outputs are combinational from the slot state and bypass inputs. The SRAM word is combinational in the same cycle as id_pc.
- Holds: the buffered instruction is used from the second hold cycle onward. The first hold cycle uses live SRAM data, which is still correct in that cycle.
- A flush during a hold clears both the slot and the buffer in the same edge.
- A WB write to the same register as a regfile read is covered by WB forwarding; no regfile write-through is required.
- rst mid-hold discards the buffer.

## Test plan
- Reset, then if_valid=1 with pc=0xBFC00000 and inst ori $1,$0,5: next cycle id_pc=0xBFC00000, issue_valid=1, rs_val=0.
- EX, MEM and WB all write $3 (values 0x11, 0x22, 0x33) while ID is addu $4,$3,$3: rs_val=rt_val=0x11. Drop ex_we: both become 0x22.
- EX lw $5 (is_load=1) with ID beq $5,$0: stallreq=1, issue_valid=0, br_taken=0, counter 0→1. Next cycle, with the load in MEM and mem_wdata=0: branch taken, br_target=pc+4+off.
- hold=1 for 3 cycles with SRAM data changed to 0xDEADBEEF after cycle 1: id_inst stays at the original word. Release hold: id_inst tracks SRAM again.
- flush and hold together while the buffer is full: next cycle valid_r=0, id_inst=0, no br_taken.
- jr $31 with $31 forwarded from MEM = 0x8000_0040: br_taken=1, br_target=0x8000_0040. Force stallreq for 2^CNT_W+2 cycles: the counter saturates at all-ones.
